// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: tag/value widths, wakeup bus record and helpers
// used by the wakeup arbiter, Rename and the reservation stations.
package pipeline_pkg;

  localparam int TAG_W      = 6;
  localparam int VALUE_W    = 32;
  localparam int NUM_WAKEUP = 4;

  // Physical tag p0 is the "no destination" tag and is never broadcast.
  localparam logic [TAG_W-1:0] TAG_NONE = 6'd0;

  typedef struct packed {
    logic               active;
    logic [TAG_W-1:0]   tag;
    logic [VALUE_W-1:0] value;
  } wakeup_t;

  // 16-bit counter increment by 0..7 that sticks at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/broadcast_rr_select.sv
// Round-robin picker: starting at rr_ptr, grants the first NUM_WAKEUP set bits
// of valid_mask, packing grant n onto bus n, and reports the pointer that
// follows the last granted requester.
module broadcast_rr_select
  import pipeline_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                  valid_mask,
  input  logic [PTR_W-1:0]                    rr_ptr,
  output logic [NUM_WAKEUP-1:0][NUM_REQ-1:0]  grant_oh,
  output logic [NUM_WAKEUP-1:0]               grant_vld,
  output logic [PTR_W-1:0]                    next_ptr
);

  // Walk requesters in rotated order, filling buses without gaps.
  always_comb begin
    int n;
    int idx;
    grant_oh  = '0;
    grant_vld = '0;
    next_ptr  = rr_ptr;
    n         = 0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid_mask[idx] && (n < NUM_WAKEUP)) begin
        grant_oh[n][idx] = 1'b1;
        grant_vld[n]     = 1'b1;
        next_ptr         = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
        n                = n + 1;
      end
    end
  end

endmodule

// File: rtl/wakeup_broadcast_arbiter.sv
// Shares the four result-broadcast buses among NUM_REQ completion ports.
// Up to four nonzero-tag completions are granted per cycle in round-robin
// order and appear, registered, on the wakeup buses one cycle later.
//
// Handshake: a transfer happens in any cycle where req_valid[i] & req_ready[i].
// req_ready is combinational from req_valid/req_tag and is never 1 while
// req_valid is 0; the requester keeps valid/tag/value steady until it sees
// ready and must not derive valid from ready. Tag-0 requests are accepted
// immediately and dropped without using a bus or moving the pointer.
module wakeup_broadcast_arbiter
  import pipeline_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int NUM_BUS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [6*NUM_REQ-1:0]     req_tag,
  input  logic [32*NUM_REQ-1:0]    req_value,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     wakeup_0_active,
  output logic [5:0]               wakeup_0_tag,
  output logic [31:0]              wakeup_0_value,
  output logic                     wakeup_1_active,
  output logic [5:0]               wakeup_1_tag,
  output logic [31:0]              wakeup_1_value,
  output logic                     wakeup_2_active,
  output logic [5:0]               wakeup_2_tag,
  output logic [31:0]              wakeup_2_value,
  output logic                     wakeup_3_active,
  output logic [5:0]               wakeup_3_tag,
  output logic [31:0]              wakeup_3_value,
  output logic                     dup_tag_error,
  output logic [15:0]              grant_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  wakeup_t                           wake_q [NUM_BUS];
  wakeup_t                           wake_d [NUM_BUS];
  logic                              dup_tag_error_q, dup_tag_error_d;
  logic [15:0]                       grant_count_q, grant_count_d;

  logic [TAG_W-1:0]                  tag_a   [NUM_REQ];
  logic [VALUE_W-1:0]                value_a [NUM_REQ];
  logic [NUM_REQ-1:0]                valid_mask;
  logic [NUM_REQ-1:0]                drop_tag0;
  logic [NUM_REQ-1:0]                granted_any;
  logic [NUM_WAKEUP-1:0][NUM_REQ-1:0] grant_oh;
  logic [NUM_WAKEUP-1:0]             grant_vld;
  logic [PTR_W-1:0]                  sel_next_ptr;
  logic [2:0]                        n_grant;
  logic                              dup_now;

  // Unpack the flat request buses and split tag-0 drops from real completions.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_a[i]      = req_tag[TAG_W*i +: TAG_W];
      value_a[i]    = req_value[VALUE_W*i +: VALUE_W];
      valid_mask[i] = req_valid[i] & (tag_a[i] != TAG_NONE);
      drop_tag0[i]  = req_valid[i] & (tag_a[i] == TAG_NONE);
    end
  end

  broadcast_rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_select (
    .valid_mask (valid_mask),
    .rr_ptr     (rr_ptr_q),
    .grant_oh   (grant_oh),
    .grant_vld  (grant_vld),
    .next_ptr   (sel_next_ptr)
  );

  // Ready for every granted requester plus every tag-0 drop.
  always_comb begin
    granted_any = '0;
    for (int k = 0; k < NUM_WAKEUP; k++) granted_any = granted_any | grant_oh[k];
    req_ready = drop_tag0 | (valid_mask & granted_any);
  end

  // Build next bus contents, duplicate detection, counter and pointer.
  always_comb begin
    n_grant = 3'd0;
    dup_now = 1'b0;
    for (int k = 0; k < NUM_BUS; k++) begin
      wake_d[k]        = '0;
      wake_d[k].active = grant_vld[k];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh[k][i]) begin
          wake_d[k].tag   = wake_d[k].tag   | tag_a[i];
          wake_d[k].value = wake_d[k].value | value_a[i];
        end
      end
      n_grant = n_grant + 3'(grant_vld[k]);
    end
    for (int a = 0; a < NUM_BUS; a++) begin
      for (int b = a + 1; b < NUM_BUS; b++) begin
        if (grant_vld[a] && grant_vld[b] && (wake_d[a].tag == wake_d[b].tag)) dup_now = 1'b1;
      end
    end
    dup_tag_error_d = dup_tag_error_q | dup_now;
    grant_count_d   = sat_add16(grant_count_q, n_grant);
    rr_ptr_d        = (|grant_vld) ? sel_next_ptr : rr_ptr_q;
  end

  // State registers; reset clears the buses immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      dup_tag_error_q <= 1'b0;
      grant_count_q   <= '0;
      for (int k = 0; k < NUM_BUS; k++) wake_q[k] <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      dup_tag_error_q <= dup_tag_error_d;
      grant_count_q   <= grant_count_d;
      for (int k = 0; k < NUM_BUS; k++) wake_q[k] <= wake_d[k];
    end
  end

  assign wakeup_0_active = wake_q[0].active;
  assign wakeup_0_tag    = wake_q[0].tag;
  assign wakeup_0_value  = wake_q[0].value;
  assign wakeup_1_active = wake_q[1].active;
  assign wakeup_1_tag    = wake_q[1].tag;
  assign wakeup_1_value  = wake_q[1].value;
  assign wakeup_2_active = wake_q[2].active;
  assign wakeup_2_tag    = wake_q[2].tag;
  assign wakeup_2_value  = wake_q[2].value;
  assign wakeup_3_active = wake_q[3].active;
  assign wakeup_3_tag    = wake_q[3].tag;
  assign wakeup_3_value  = wake_q[3].value;
  assign dup_tag_error   = dup_tag_error_q;
  assign grant_count     = grant_count_q;

endmodule

// File: tb/tb_wakeup_broadcast_arbiter.sv
// Bench for wakeup_broadcast_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the grant rules.
module tb_wakeup_broadcast_arbiter;

  localparam int N = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [6*N-1:0]  req_tag;
  logic [32*N-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            wakeup_0_active, wakeup_1_active, wakeup_2_active, wakeup_3_active;
  logic [5:0]      wakeup_0_tag, wakeup_1_tag, wakeup_2_tag, wakeup_3_tag;
  logic [31:0]     wakeup_0_value, wakeup_1_value, wakeup_2_value, wakeup_3_value;
  logic            dup_tag_error;
  logic [15:0]     grant_count;

  wakeup_broadcast_arbiter #(.NUM_REQ(N), .NUM_BUS(4)) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_tag (req_tag), .req_value (req_value),
    .req_ready (req_ready),
    .wakeup_0_active (wakeup_0_active), .wakeup_0_tag (wakeup_0_tag), .wakeup_0_value (wakeup_0_value),
    .wakeup_1_active (wakeup_1_active), .wakeup_1_tag (wakeup_1_tag), .wakeup_1_value (wakeup_1_value),
    .wakeup_2_active (wakeup_2_active), .wakeup_2_tag (wakeup_2_tag), .wakeup_2_value (wakeup_2_value),
    .wakeup_3_active (wakeup_3_active), .wakeup_3_tag (wakeup_3_tag), .wakeup_3_value (wakeup_3_value),
    .dup_tag_error (dup_tag_error),
    .grant_count (grant_count)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [38:0] exp_q[$];
  int          m_ptr;
  bit          m_dup;
  int          m_count;

  // requester-side stimulus state
  logic        v   [N];
  logic [5:0]  t   [N];
  logic [31:0] val [N];
  logic        acc [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] bus_word(input int k);
    case (k)
      0:       return {wakeup_0_active, wakeup_0_tag, wakeup_0_value};
      1:       return {wakeup_1_active, wakeup_1_tag, wakeup_1_value};
      2:       return {wakeup_2_active, wakeup_2_tag, wakeup_2_value};
      default: return {wakeup_3_active, wakeup_3_tag, wakeup_3_value};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = v[i];
      req_tag[6*i +: 6]    = t[i];
      req_value[32*i +: 32] = val[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; t[i] = 6'd0; val[i] = 32'd0; acc[i] = 1'b0;
    end
  endtask

  // Drops every requester whose item was taken last cycle.
  task automatic retire_accepted();
    for (int i = 0; i < N; i++) if (acc[i]) v[i] = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_dup = 1'b0; m_count = 0;
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 4; k++) check_eq($sformatf("%s_bus%0d", tag, k), bus_word(k), 39'd0);
    check_eq({tag, "_dup"}, dup_tag_error, 0);
    check_eq({tag, "_count"}, grant_count, 0);
  endtask

  // One clock of traffic: predicts ready now and the buses after the edge.
  task automatic do_cycle();
    int          gl[$];
    logic [N-1:0] in_g;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    in_g = '0;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (m_ptr + off) % N;
      if (v[idx] && t[idx] != 6'd0 && gl.size() < 4) begin
        gl.push_back(idx);
        in_g[idx] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = v[i] && (t[i] == 6'd0 || in_g[i]);
    check_eq("ready", req_ready, exp_rdy);
    for (int k = 0; k < 4; k++) begin
      if (k < gl.size()) exp_q.push_back({1'b1, t[gl[k]], val[gl[k]]});
      else               exp_q.push_back(39'd0);
    end
    for (int a = 0; a < gl.size(); a++)
      for (int b = a + 1; b < gl.size(); b++)
        if (t[gl[a]] == t[gl[b]]) m_dup = 1'b1;
    m_count = m_count + gl.size();
    if (m_count > 65535) m_count = 65535;
    if (gl.size() > 0) m_ptr = (gl[gl.size()-1] + 1) % N;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check_eq($sformatf("bus%0d", k), bus_word(k), exp_q.pop_front());
    check_eq("dup", dup_tag_error, m_dup);
    check_eq("count", grant_count, m_count);
    check_eq("rr_ptr", dut.rr_ptr_q, m_ptr);
    for (int i = 0; i < N; i++) acc[i] = exp_rdy[i];
  endtask

  // Reset held across one edge; requesters are cleared with the design.
  task automatic pulse_reset();
    reset = 1'b1;
    clear_reqs();
    drive();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("rst");
    check_eq("rst_ptr", dut.rr_ptr_q, 0);
  endtask

  task automatic new_random_item(input int i);
    v[i]   = ($urandom_range(0, 3) != 0);
    t[i]   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
    val[i] = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    clear_reqs();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_cleared("idle");
    check_eq("idle_ptr", dut.rr_ptr_q, 0);
    do_cycle();

    // single request on port 2
    pulse_reset();
    v[2] = 1'b1; t[2] = 6'd33; val[2] = 32'h1234_5678;
    do_cycle();
    check_eq("single_bus0", bus_word(0), {1'b1, 6'd33, 32'h1234_5678});
    check_eq("single_count", grant_count, 1);
    retire_accepted();
    do_cycle();

    // all six valid, held until accepted
    pulse_reset();
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; t[i] = 6'(40 + i); val[i] = 32'hA000 + i; end
    do_cycle();
    check_eq("all6_ptr_a", dut.rr_ptr_q, 4);
    check_eq("all6_bus3", bus_word(3), {1'b1, 6'd43, 32'hA003});
    retire_accepted();
    do_cycle();
    check_eq("all6_ptr_b", dut.rr_ptr_q, 0);
    check_eq("all6_bus1", bus_word(1), {1'b1, 6'd45, 32'hA005});
    check_eq("all6_bus2", bus_word(2), 39'd0);
    retire_accepted();

    // tag-0 mix: port 1 dropped, port 3 broadcast
    v[1] = 1'b1; t[1] = 6'd0;  val[1] = 32'hDEAD;
    v[3] = 1'b1; t[3] = 6'd50; val[3] = 32'hBEEF;
    do_cycle();
    check_eq("tag0_bus0", bus_word(0), {1'b1, 6'd50, 32'hBEEF});
    check_eq("tag0_bus1", bus_word(1), 39'd0);
    check_eq("tag0_ptr", dut.rr_ptr_q, 4);
    retire_accepted();

    // duplicate tag on ports 0 and 1
    v[0] = 1'b1; t[0] = 6'd37; val[0] = 32'h1;
    v[1] = 1'b1; t[1] = 6'd37; val[1] = 32'h2;
    do_cycle();
    check_eq("dup_bus0", bus_word(0), {1'b1, 6'd37, 32'h1});
    check_eq("dup_bus1", bus_word(1), {1'b1, 6'd37, 32'h2});
    check_eq("dup_set", dup_tag_error, 1);
    retire_accepted();
    repeat (3) do_cycle();
    check_eq("dup_sticky", dup_tag_error, 1);

    // random traffic with periodic resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 250) pulse_reset();
      for (int i = 0; i < N; i++) if (!v[i] || acc[i]) new_random_item(i);
      do_cycle();
    end

    // asynchronous reset while buses are active
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; t[i] = 6'(10 + i); val[i] = $urandom; end
    do_cycle();
    check_eq("async_pre_active", wakeup_0_active, 1);
    reset = 1'b1;
    #1;
    check_cleared("async");
    clear_reqs();
    drive();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("async_ptr", dut.rr_ptr_q, 0);
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; t[i] = 6'(20 + i); val[i] = $urandom; end
    do_cycle();
    check_eq("async_first", bus_word(0), {1'b1, 6'd20, val[0]});

    // saturate the broadcast counter with full load
    for (int c = 0; c < 16500; c++) begin
      for (int i = 0; i < N; i++)
        if (acc[i]) begin t[i] = 6'($urandom_range(1, 63)); val[i] = $urandom; end
      do_cycle();
    end
    check_eq("count_sat", grant_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
